// File: rtl/truth_table_sweep_pkg.sv
// Shared types and default constants for the truth_table_sweep block.
package truth_table_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/truth_table_sweep_if.sv
// Bus bundle between the sweep block (slave) and the bench/BIST side (master).
interface truth_table_sweep_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 1,
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] expected_sig;
  logic [OUT_W-1:0] dut_resp;
  logic [IN_W-1:0]  vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [IN_W-1:0]  rd_addr;
  logic [OUT_W-1:0] rd_data;

  modport master (
    output start, abort, expected_sig, dut_resp, rd_addr,
    input  vec_out, busy, done, pass, signature, rd_data
  );

  modport slave (
    input  start, abort, expected_sig, dut_resp, rd_addr,
    output vec_out, busy, done, pass, signature, rd_data
  );
endinterface

// File: rtl/truth_table_sweep_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback
// from the MSB and folds the zero-extended response word into the LSBs.
module sweep_misr #(
  parameter int               SIG_W    = 16,
  parameter int               OUT_W    = 1,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt
);

  // Next signature is exposed so the owner can compare it in the same cycle.
  always_comb begin
    sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(data);
  end

  // Seed on load, fold on enable, otherwise hold (abort freezes the value).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sig <= SIG_SEED;
    else if (load) sig <= SIG_SEED;
    else if (en)   sig <= sig_nxt;
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Exhaustive truth-table sweep generator with MISR response compaction.
// Optional macro TRUTH_TABLE_SWEEP_CAPTURE_EN adds a per-vector response bank
// readable through rd_addr/rd_data; without it rd_data is tied low.
//
// state | meaning
// IDLE  | waiting for start, vec_out parked at 0
// DRIVE | walking vectors, HOLD_CYCLES clocks each, sampling on the last
// DONE  | sweep finished, signature/pass held until start or abort
module truth_table_sweep
  import truth_table_sweep_pkg::*;
#(
  parameter int               IN_W        = 4,
  parameter int               OUT_W       = 1,
  parameter int               HOLD_CYCLES = 20,
  parameter int               SIG_W       = 16,
  parameter logic [SIG_W-1:0] SIG_POLY    = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0] SIG_SEED    = DEF_SIG_SEED
) (
  input logic                clk,
  input logic                rst,
  truth_table_sweep_if.slave bus
);

  localparam int              HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [IN_W-1:0] VEC_LAST  = '1;

  state_t           state, state_nxt;
  logic [HC_W-1:0]  hold_cnt;
  logic [IN_W-1:0]  vec_q;
  logic [SIG_W-1:0] exp_q;
  logic [SIG_W-1:0] sig_nxt;
  logic             accept, sample, finish;
  logic             busy_q, done_q, pass_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-cycle strobes; abort overrides everything.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    finish    = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            accept    = 1'b1;
            state_nxt = DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            sample = 1'b1;
            if (vec_q == VEC_LAST) begin
              finish    = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Hold/vector counters, golden latch and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      vec_q    <= '0;
      exp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      busy_q <= (state_nxt == DRIVE);
      done_q <= finish;
      if (bus.abort) begin
        hold_cnt <= '0;
        vec_q    <= '0;
        pass_q   <= 1'b0;
      end else if (accept) begin
        hold_cnt <= '0;
        vec_q    <= '0;
        pass_q   <= 1'b0;
        exp_q    <= bus.expected_sig;
      end else if (state == DRIVE) begin
        if (sample) begin
          hold_cnt <= '0;
          vec_q    <= vec_q + IN_W'(1);
          if (finish) pass_q <= (sig_nxt == exp_q);
        end else begin
          hold_cnt <= hold_cnt + HC_W'(1);
        end
      end
    end
  end

  sweep_misr #(
    .SIG_W   (SIG_W),
    .OUT_W   (OUT_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .en     (sample),
    .data   (bus.dut_resp),
    .sig    (bus.signature),
    .sig_nxt(sig_nxt)
  );

`ifdef TRUTH_TABLE_SWEEP_CAPTURE_EN
  logic [OUT_W-1:0] bank [2**IN_W];

  // Response bank: cleared on reset and on every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**IN_W; i++) bank[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 2**IN_W; i++) bank[i] <= '0;
    end else if (sample) begin
      bank[vec_q] <= bus.dut_resp;
    end
  end

  assign bus.rd_data = bank[bus.rd_addr];
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.rd_addr;
  assign bus.rd_data    = '0;
`endif

  assign bus.vec_out = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: a tiny IN_W=2/HOLD=1 instance and a default
// IN_W=4/HOLD=20 instance, with expected vectors and signatures queued at
// start and consumed as the DUT presents them.
module tb_truth_table_sweep;

  localparam int NH = 16 * 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  vec_q  [$];
  logic [15:0] sig_q  [$];
  logic        pass_q [$];
  bit          resp_mode = 1'b0;

  truth_table_sweep_if #(.IN_W(2), .OUT_W(1), .SIG_W(16)) ifa ();
  truth_table_sweep_if #(.IN_W(4), .OUT_W(1), .SIG_W(16)) ifb ();

  assign ifa.dut_resp = 1'b0;
  assign ifb.dut_resp = resp_mode ? (ifb.vec_out == 4'd5) : ^ifb.vec_out;

  truth_table_sweep #(.IN_W(2), .OUT_W(1), .HOLD_CYCLES(1), .SIG_W(16)) ua (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  truth_table_sweep #(.IN_W(4), .OUT_W(1), .HOLD_CYCLES(20), .SIG_W(16)) ub (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
  endfunction

  function automatic logic [15:0] model_sig(input bit mode);
    logic [15:0] s;
    logic [3:0]  vv;
    logic        r;
    s = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      vv = v[3:0];
      r  = mode ? (vv == 4'd5) : ^vv;
      s  = misr_step(s, r);
    end
    return s;
  endfunction

  // Full sweep on the IN_W=4 instance; restart_at > 0 re-pulses start mid-DRIVE.
  task automatic sweep_b(input logic [15:0] exp_sig, input int restart_at);
    logic [15:0] gold;
    logic [3:0]  cur;
    int          first_done;
    gold       = model_sig(resp_mode);
    first_done = -1;
    cur        = '0;
    for (int v = 0; v < 16; v++) vec_q.push_back(v[3:0]);
    sig_q.push_back(gold);
    pass_q.push_back(gold == exp_sig);
    ifb.expected_sig = exp_sig;
    ifb.start        = 1'b1;
    tick;
    ifb.start        = 1'b0;
    ifb.expected_sig = ~exp_sig;
    for (int j = 0; j <= NH + 4; j++) begin
      if (j > 0) begin
        ifb.start = (j == restart_at);
        tick;
      end
      if (j < NH && (j % 20) == 0) begin
        cur = vec_q.pop_front();
        check("vec_out", {28'b0, ifb.vec_out}, {28'b0, cur});
      end
      if (j < NH && (j % 20) == 19) check("vec_hold", {28'b0, ifb.vec_out}, {28'b0, cur});
      if (j == 0)      check("busy_start", {31'b0, ifb.busy}, 32'd1);
      if (j == NH - 1) check("busy_last", {31'b0, ifb.busy}, 32'd1);
      if (j == NH)     check("busy_done", {31'b0, ifb.busy}, 32'd0);
      if (j == NH + 1) check("done_pulse", {31'b0, ifb.done}, 32'd0);
      if (j == NH + 1) check("vec_park", {28'b0, ifb.vec_out}, 32'd0);
      if (ifb.done && first_done < 0) first_done = j;
    end
    ifb.start = 1'b0;
    check("done_at", first_done, NH);
    check("sig_b", {16'b0, ifb.signature}, {16'b0, sig_q.pop_front()});
    check("pass_b", {31'b0, ifb.pass}, {31'b0, pass_q.pop_front()});
  endtask

  initial begin
    logic [15:0] gold;
    logic [15:0] held;
    logic [3:0]  cur;
    bit          seen;

    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.expected_sig = '0; ifa.rd_addr = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.expected_sig = '0; ifb.rd_addr = '0;

    #12;
    check("rst_vec", {28'b0, ifb.vec_out}, 32'd0);
    check("rst_busy", {31'b0, ifb.busy}, 32'd0);
    check("rst_done", {31'b0, ifb.done}, 32'd0);
    check("rst_pass", {31'b0, ifb.pass}, 32'd0);
    check("rst_sig", {16'b0, ifb.signature}, 32'h0000FFFF);
    check("rst_rd", {31'b0, ifb.rd_data}, 32'd0);
    rst = 1'b0;
    tick;

    // Small instance: one clock per vector, zero responses.
    for (int v = 0; v < 4; v++) vec_q.push_back(v[3:0]);
    sig_q.push_back(16'h0E1F);
    ifa.expected_sig = 16'h0E1F;
    ifa.start = 1'b1;
    tick;
    ifa.start = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) tick;
      if (j < 4) begin
        cur = vec_q.pop_front();
        check("a_vec", {30'b0, ifa.vec_out}, {28'b0, cur});
      end
      if (j == 3) check("a_done_early", {31'b0, ifa.done}, 32'd0);
      if (j == 4) begin
        check("a_done", {31'b0, ifa.done}, 32'd1);
        check("a_vec_park", {30'b0, ifa.vec_out}, 32'd0);
        check("a_sig", {16'b0, ifa.signature}, {16'b0, sig_q.pop_front()});
        check("a_pass", {31'b0, ifa.pass}, 32'd1);
      end
      if (j == 5) check("a_done_pulse", {31'b0, ifa.done}, 32'd0);
    end

    // XOR responses: matching golden (with an ignored restart), then a flipped bit.
    resp_mode = 1'b0;
    gold = model_sig(1'b0);
    sweep_b(gold, 100);
    sweep_b(gold ^ 16'h0001, 0);

    // Abort 50 cycles into a sweep.
    sweep_b(gold, 0);
    ifb.expected_sig = gold;
    ifb.start = 1'b1;
    tick;
    ifb.start = 1'b0;
    repeat (50) tick;
    ifb.abort = 1'b1;
    held = ifb.signature;
    tick;
    ifb.abort = 1'b0;
    check("abort_busy", {31'b0, ifb.busy}, 32'd0);
    check("abort_vec", {28'b0, ifb.vec_out}, 32'd0);
    check("abort_pass", {31'b0, ifb.pass}, 32'd0);
    check("abort_sig", {16'b0, ifb.signature}, {16'b0, held});
    seen = 1'b0;
    for (int j = 0; j < NH + 5; j++) begin
      if (ifb.done) seen = 1'b1;
      tick;
    end
    check("abort_no_done", {31'b0, seen}, 32'd0);

    // start and abort together: stays idle, signature not reseeded.
    held = ifb.signature;
    ifb.start = 1'b1;
    ifb.abort = 1'b1;
    tick;
    ifb.start = 1'b0;
    ifb.abort = 1'b0;
    tick;
    check("sa_busy", {31'b0, ifb.busy}, 32'd0);
    check("sa_sig", {16'b0, ifb.signature}, {16'b0, held});
    check("sa_vec", {28'b0, ifb.vec_out}, 32'd0);

    // Asynchronous reset between edges mid-sweep, then a clean sweep.
    ifb.start = 1'b1;
    tick;
    ifb.start = 1'b0;
    repeat (30) tick;
    #3 rst = 1'b1;
    #1;
    check("mrst_vec", {28'b0, ifb.vec_out}, 32'd0);
    check("mrst_busy", {31'b0, ifb.busy}, 32'd0);
    check("mrst_done", {31'b0, ifb.done}, 32'd0);
    check("mrst_pass", {31'b0, ifb.pass}, 32'd0);
    check("mrst_sig", {16'b0, ifb.signature}, 32'h0000FFFF);
    #1 rst = 1'b0;
    tick;
    sweep_b(gold, 0);

    // Single-hot response at vector 5, then read back the capture bank.
    resp_mode = 1'b1;
    sweep_b(model_sig(1'b1), 0);
    for (int a = 0; a < 16; a++) begin
      ifb.rd_addr = a[3:0];
      #1;
`ifdef TRUTH_TABLE_SWEEP_CAPTURE_EN
      check("rd_data", {31'b0, ifb.rd_data}, (a == 5) ? 32'd1 : 32'd0);
`else
      check("rd_data_tied", {31'b0, ifb.rd_data}, 32'd0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
